// File: rtl/boot_loader_if.sv
// boot_loader_if: byte-stream upstream handshake plus instruction-memory write port.
interface boot_loader_if #(parameter int ADDR_W = 10);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  modport master(output in_valid, in_data, input in_ready, im_we, im_addr, im_wdata);
  modport slave(input in_valid, in_data, output in_ready, im_we, im_addr, im_wdata);
endinterface

// File: rtl/boot_loader.sv
// boot_loader: receives a length-prefixed byte stream, writes 32-bit words into
// instruction memory and releases the CPU reset once the whole image is loaded.
module boot_loader #(parameter int ADDR_W = 10) (
  input  logic          clk,
  input  logic          rst,
  boot_loader_if.slave  bus,
  output logic          cpu_rst,
  output logic          done,
  output logic          err
);
  typedef enum logic [2:0] {LEN_HI, LEN_LO, DATA, DONE, ERR} state_t;
  state_t            state_q, state_d;
  logic [15:0]       n_q, n_d, n_full;
  logic [23:0]       asm_q, asm_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [ADDR_W-1:0] widx_q, widx_d, im_addr_q, im_addr_d;
  logic [31:0]       im_wdata_q, im_wdata_d;
  logic              in_ready_q, in_ready_d, im_we_q, im_we_d;
  logic              cpu_rst_q, cpu_rst_d, done_q, done_d, err_q, err_d;
  logic              fire, last;
  always_comb begin
    fire       = in_ready_q & bus.in_valid;
    n_full     = {n_q[15:8], bus.in_data};
    last       = (n_q - 16'd1) == 16'(widx_q);
    state_d    = state_q;
    n_d        = n_q;
    asm_d      = asm_q;
    bcnt_d     = bcnt_q;
    widx_d     = widx_q;
    im_addr_d  = im_addr_q;
    im_wdata_d = im_wdata_q;
    im_we_d    = 1'b0;
    case (state_q)
      LEN_HI: if (fire) begin
        n_d     = {bus.in_data, 8'h00};
        state_d = LEN_LO;
      end
      LEN_LO: if (fire) begin
        n_d     = n_full;
        bcnt_d  = 2'd0;
        widx_d  = '0;
        state_d = (n_full == 16'd0) ? DONE :
                  ({1'b0, n_full} > (17'd1 << ADDR_W)) ? ERR : DATA;
      end
      DATA: if (fire) begin
        asm_d  = {asm_q[15:0], bus.in_data};
        bcnt_d = bcnt_q + 2'd1;
        if (bcnt_q == 2'd3) begin
          im_we_d    = 1'b1;
          im_addr_d  = widx_q;
          im_wdata_d = {asm_q, bus.in_data};
          widx_d     = widx_q + ADDR_W'(1);
          state_d    = last ? DONE : DATA;
        end
      end
      default: ;
    endcase
    // outputs are registered from the next state so they line up with state_q
    in_ready_d = state_d inside {LEN_HI, LEN_LO, DATA};
    cpu_rst_d  = cpu_rst_q & (state_q != DONE);
    done_d     = state_d == DONE;
    err_d      = state_d == ERR;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= LEN_HI;
      n_q        <= '0;
      asm_q      <= '0;
      bcnt_q     <= '0;
      widx_q     <= '0;
      im_addr_q  <= '0;
      im_wdata_q <= '0;
      im_we_q    <= 1'b0;
      in_ready_q <= 1'b0;
      cpu_rst_q  <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      asm_q      <= asm_d;
      bcnt_q     <= bcnt_d;
      widx_q     <= widx_d;
      im_addr_q  <= im_addr_d;
      im_wdata_q <= im_wdata_d;
      im_we_q    <= im_we_d;
      in_ready_q <= in_ready_d;
      cpu_rst_q  <= cpu_rst_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end
  assign bus.in_ready = in_ready_q;
  assign bus.im_we    = im_we_q;
  assign bus.im_addr  = im_addr_q;
  assign bus.im_wdata = im_wdata_q;
  assign cpu_rst      = cpu_rst_q;
  assign done         = done_q;
  assign err          = err_q;
endmodule

// File: doc/boot_loader.md
BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 Parameter: ADDR_W, default 10, instruction-memory word-address width (1024 words).
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  in  1  reset, asynchronous and active-low.
REQ-004 Port: in_valid  in  1  upstream byte available.
REQ-005 Port: in_data  in  8  upstream byte.
REQ-006 Port: in_ready  out  1  loader accepts byte; transfer occurs when in_valid and in_ready are both high at a rising edge.
REQ-007 Port: im_we  out  1  instruction-memory word write strobe.
REQ-008 Port: im_addr  out  ADDR_W  instruction-memory word address.
REQ-009 Port: im_wdata  out  32  instruction word to write.
REQ-010 Port: cpu_rst  out  1  active-high reset to the CPU core; held high until load completes.
REQ-011 Port: done  out  1  load completed successfully.
REQ-012 Port: err  out  1  load aborted on illegal length.

Function
REQ-013 The block SHALL implement FSM states LEN_HI, LEN_LO, DATA, DONE, ERR.
REQ-014 Stream format SHALL be a 16-bit word count N, high byte first, followed by N*4 data bytes, each word most-significant byte first.
REQ-015 in_ready SHALL be 1 in LEN_HI, LEN_LO and DATA, and 0 in DONE and ERR; in_ready SHALL be a function of state only (no dependence on in_valid).
REQ-016 LEN_HI: on transfer, latch N[15:8] and go to LEN_LO.
REQ-017 LEN_LO: on transfer, latch N[7:0], then: N==0 -> DONE; N > 2^ADDR_W -> ERR; else -> DATA with byte counter=0, word index=0.
REQ-018 DATA: each transfer SHALL shift the byte into a 32-bit assembly register (new byte enters bits [7:0]) and increment a 2-bit byte counter.
REQ-019 On the transfer of the 4th byte of a word, the block SHALL, on the following cycle, assert im_we for exactly one cycle with im_wdata = assembled word and im_addr = word index (registered outputs, latency 1 cycle from last byte).
REQ-020 Word index SHALL increment after each word; word index for word k (0-based) SHALL equal k; no wrap-around occurs because N <= 2^ADDR_W.
REQ-021 After the 4th byte of word N-1, the FSM SHALL enter DONE in the same cycle im_we pulses.
REQ-022 Cycles with in_valid=0 SHALL leave all state unchanged; back-to-back bytes on consecutive cycles SHALL be accepted at one per cycle with no loss.
REQ-023 im_we SHALL be 0 in every cycle except the REQ-019 pulse; im_addr/im_wdata hold last written values when im_we=0.
REQ-024 cpu_rst SHALL fall to 0 one cycle after the FSM enters DONE (i.e. after the final im_we pulse completes) and SHALL remain 0 until reset.
REQ-025 done SHALL be 1 exactly while in DONE; err SHALL be 1 exactly while in ERR.
REQ-026 DONE and ERR SHALL be terminal; only rst exits them.
REQ-027 In ERR, cpu_rst SHALL remain 1 and im_we SHALL remain 0.

Reset
REQ-028 While rst=0: state=LEN_HI, in_ready=0, im_we=0, im_addr=0, im_wdata=0, cpu_rst=1, done=0, err=0, counters=0.
REQ-029 in_ready SHALL rise to 1 on the first clock edge after rst deasserts.
REQ-030 Reset asserted mid-load SHALL abort immediately (asynchronously) with no further im_we, and the next load SHALL restart at LEN_HI, word index 0; memory contents already written are not cleared.

Verification
REQ-031 Stream 00 02 12 34 56 78 AB CD EF 01, in_valid always 1 -> im_we pulses: addr 0 data 0x12345678, addr 1 data 0xABCDEF01; done=1; cpu_rst falls one cycle after second pulse.
REQ-032 Stream 00 00 -> no im_we; done=1; cpu_rst=0 two cycles after second length byte.
REQ-033 Stream 04 01 (N=1025, ADDR_W=10) -> err=1, in_ready=0, cpu_rst stays 1, no im_we for 100 further cycles of in_valid=1.
REQ-034 N=1 with in_valid toggling 1,0,0,1 between bytes 11 22 33 44 -> single write addr 0 data 0x11223344, no duplicate or missing bytes.
REQ-035 rst pulsed low after 2 of 4 data bytes of word 0, then stream 00 01 DE AD BE EF -> single write addr 0 data 0xDEADBEEF; done=1.
REQ-036 N=1024 full load of incrementing words -> 1024 writes, last addr 0x3FF, done=1, err=0.
